pll_lock_detector: RTL and testbench
====================================

// Module: pll_lock_detector
// PURPOSE
//   Digital lock detector and frequency meter, downstream of the delay-line PLL.
//   Counts rising edges of the PLL divided feedback clock over a fixed window of
//   system-clock cycles and compares the count against a programmed target.
//   Drives the lock flag and frequency status to uo_out and the test logic.
// PARAMETERS
//   WINDOW_CYC   1024  measurement window length in clk cycles (>=4)
//   CNT_W        16    width of edge counter, target and meas_count
//   TOL_W        8     width of tolerance input
//   LOCK_N       4     consecutive in-tolerance windows required to assert lock
// PORTS
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   en           in   1      measurement enable; low forces IDLE
//   fb_in        in   1      PLL feedback clock, asynchronous to clk
//   target       in   CNT_W  expected edge count per window
//   tol          in   TOL_W  allowed |count-target|
//   meas_count   out  CNT_W  edge count of last completed window
//   meas_valid   out  1      1-cycle pulse when meas_count updates
//   too_fast     out  1      last window count > target+tol
//   too_slow     out  1      last window count < target-tol
//   lock         out  1      PLL declared locked
// BEHAVIOUR
//   - One clock, synchronous active-high reset. Reset: all outputs 0, FSM IDLE,
//     edge counter 0, good-window counter 0, sync flops 0.
//   - fb_in passes a 2-flop synchroniser plus a 3rd flop for rising-edge detect;
//     edge pulse lags fb_in by 2-3 clk cycles. Edges at fb_in faster than clk/2
//     are undercounted (out of spec, not flagged).
//   - FSM: IDLE -> MEASURE when en=1 (next cycle). MEASURE lasts exactly
//     WINDOW_CYC cycles, counting edge pulses; edge on the last MEASURE cycle
//     counts. Then EVAL for 1 cycle; edges in EVAL are dropped. EVAL -> MEASURE
//     if en=1, else IDLE. Window period = WINDOW_CYC+1 cycles.
//   - Edge counter saturates at 2^CNT_W-1; cleared on entry to MEASURE.
//   - EVAL: meas_count <= count; meas_valid=1 the following cycle for 1 cycle.
//     diff = |count-target| computed at CNT_W+1 bits (no wrap). good = diff<=tol
//     (tol zero-extended). too_fast/too_slow registered with meas_count; both 0
//     when good. target+tol overflow handled by the CNT_W+1 width.
//   - Lock: good window increments good_cnt (saturates at LOCK_N); lock rises in
//     the cycle meas_valid is asserted for the LOCK_N-th consecutive good window.
//     Bad window: good_cnt<=0 and lock falls with that window's meas_valid.
//   - en deasserted in any state: next cycle IDLE, lock=0, good_cnt=0, counter
//     cleared; meas_count/too_fast/too_slow hold last value. No meas_valid for
//     an aborted window.
//   - target/tol sampled in EVAL only; changes mid-window take effect at EVAL.
//   - rst mid-window wins over all events in that cycle.
// CONFIGURATION
//   LOCK_HYST_EN defined: once locked, lock drops only after 2 consecutive bad
//     windows; one isolated bad window keeps lock=1 but clears good_cnt to
//     LOCK_N-1 (next good window restores it). Unlock clears good_cnt to 0.
//   Not defined: lock drops on the first bad window (as above).
// TESTING (WINDOW_CYC=1024, CNT_W=16, LOCK_N=4)
//   1. rst=1 3 cycles with fb toggling -> all outputs 0, no meas_valid.
//   2. fb period 8 clk, target=128, tol=2, en=1 -> meas_count in 127..129 each
//      window, meas_valid every 1025 cycles, lock=1 with 4th meas_valid.
//   3. Locked, switch fb period to 7 clk -> next full window count ~146,
//      too_fast=1, lock=0 with that meas_valid (LOCK_HYST_EN: after 2nd window).
//   4. fb held constant, target=128, tol=2 -> meas_count=0, too_slow=1, lock=0.
//   5. Locked, en=0 for 1 cycle mid-window -> lock=0 next cycle, no meas_valid
//      for aborted window, relock needs 4 fresh good windows.
//   6. target=65535, tol=255, fb period 2 clk -> count 512, diff no wrap,
//      too_slow=1; target=0, tol=0, fb static -> good, lock after 4 windows.

Source files
------------

// File: rtl/pll_lock_detector.sv
// Lock detector and frequency meter: counts synchronised feedback-clock edges over a
// fixed clk window and compares them with a target. Optional macro: LOCK_HYST_EN.
module pll_lock_detector #(
   parameter int WINDOW_CYC = 1024,
   parameter int CNT_W      = 16,
   parameter int TOL_W      = 8,
   parameter int LOCK_N     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fb_in,
   input  logic [CNT_W-1:0] target,
   input  logic [TOL_W-1:0] tol,
   output logic [CNT_W-1:0] meas_count,
   output logic             meas_valid,
   output logic             too_fast,
   output logic             too_slow,
   output logic             lock
);

   localparam int                WIN_W    = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYC - 1);
   localparam int                GOOD_W   = $clog2(LOCK_N + 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEASURE,
      S_EVAL
   } state_t;

   state_t r_state, w_state_nxt;

   logic              r_fb_s1, r_fb_s2, r_fb_s3;
   logic [WIN_W-1:0]  r_win_cnt;
   logic [CNT_W-1:0]  r_edge_cnt;
   logic [GOOD_W-1:0] r_good_cnt;
   logic [CNT_W-1:0]  r_meas_count;
   logic              r_meas_valid, r_too_fast, r_too_slow, r_lock;
`ifdef LOCK_HYST_EN
   logic              r_bad_once;
`endif

   logic              w_edge, w_good, w_fast, w_slow;
   logic [CNT_W:0]    w_cnt_ext, w_tgt_ext, w_tol_ext, w_diff;
   logic [GOOD_W-1:0] w_good_inc;

   assign w_edge = r_fb_s2 & ~r_fb_s3;

   // Extra bit keeps |count-target| and target+tol from wrapping.
   assign w_cnt_ext  = {1'b0, r_edge_cnt};
   assign w_tgt_ext  = {1'b0, target};
   assign w_tol_ext  = (CNT_W+1)'(tol);
   assign w_diff     = (w_cnt_ext >= w_tgt_ext) ? (w_cnt_ext - w_tgt_ext)
                                                : (w_tgt_ext - w_cnt_ext);
   assign w_good     = (w_diff <= w_tol_ext);
   assign w_fast     = !w_good && (w_cnt_ext > w_tgt_ext);
   assign w_slow     = !w_good && (w_cnt_ext < w_tgt_ext);
   assign w_good_inc = (r_good_cnt == GOOD_MAX) ? GOOD_MAX : r_good_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: next state defaults to the current one so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (en) w_state_nxt = S_MEASURE;
         S_MEASURE: begin
            if (!en)                         w_state_nxt = S_IDLE;
            else if (r_win_cnt == WIN_LAST) w_state_nxt = S_EVAL;
         end
         S_EVAL:    w_state_nxt = en ? S_MEASURE : S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: every flop here updates with <= so all of them see pre-edge values of each other.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fb_s1      <= 1'b0;
         r_fb_s2      <= 1'b0;
         r_fb_s3      <= 1'b0;
         r_win_cnt    <= '0;
         r_edge_cnt   <= '0;
         r_good_cnt   <= '0;
         r_meas_count <= '0;
         r_meas_valid <= 1'b0;
         r_too_fast   <= 1'b0;
         r_too_slow   <= 1'b0;
         r_lock       <= 1'b0;
`ifdef LOCK_HYST_EN
         r_bad_once   <= 1'b0;
`endif
      end else begin
         r_fb_s1      <= fb_in;
         r_fb_s2      <= r_fb_s1;
         r_fb_s3      <= r_fb_s2;
         r_meas_valid <= 1'b0;
         if (!en) begin
            // Abort: result registers hold, lock state is discarded.
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_good_cnt <= '0;
            r_lock     <= 1'b0;
`ifdef LOCK_HYST_EN
            r_bad_once <= 1'b0;
`endif
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_win_cnt  <= '0;
                  r_edge_cnt <= '0;
               end
               S_MEASURE: begin
                  r_win_cnt <= r_win_cnt + 1'b1;
                  if (w_edge && (r_edge_cnt != {CNT_W{1'b1}}))
                     r_edge_cnt <= r_edge_cnt + 1'b1;
               end
               S_EVAL: begin
                  r_win_cnt    <= '0;
                  r_edge_cnt   <= '0;
                  r_meas_count <= r_edge_cnt;
                  r_meas_valid <= 1'b1;
                  r_too_fast   <= w_fast;
                  r_too_slow   <= w_slow;
                  if (w_good) begin
                     r_good_cnt <= w_good_inc;
                     r_lock     <= (w_good_inc == GOOD_MAX);
`ifdef LOCK_HYST_EN
                     r_bad_once <= 1'b0;
`endif
                  end else begin
`ifdef LOCK_HYST_EN
                     if (r_lock && !r_bad_once) begin
                        r_good_cnt <= GOOD_MAX - 1'b1;
                        r_bad_once <= 1'b1;
                     end else begin
                        r_good_cnt <= '0;
                        r_lock     <= 1'b0;
                        r_bad_once <= 1'b0;
                     end
`else
                     r_good_cnt <= '0;
                     r_lock     <= 1'b0;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign meas_count = r_meas_count;
   assign meas_valid = r_meas_valid;
   assign too_fast   = r_too_fast;
   assign too_slow   = r_too_slow;
   assign lock       = r_lock;

endmodule

// File: tb/tb_pll_lock_detector.sv
// Scoreboard bench for pll_lock_detector: stimulus queues expected window results,
// a monitor checks them on each meas_valid pulse.
`timescale 1ns/1ps
module tb_pll_lock_detector;
   localparam int CNT_W      = 16;
   localparam int TOL_W      = 8;
   localparam int WINDOW_CYC = 1024;
   localparam int PER        = WINDOW_CYC + 1;
`ifdef LOCK_HYST_EN
   localparam logic HYST = 1'b1;
`else
   localparam logic HYST = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             fb_in = 1'b0;
   logic [CNT_W-1:0] target = '0;
   logic [TOL_W-1:0] tol = '0;
   logic [CNT_W-1:0] meas_count;
   logic             meas_valid, too_fast, too_slow, lock;

   typedef struct {
      int   lo;
      int   hi;
      logic tf;
      logic ts;
      logic lk;
      logic chk_per;
   } exp_t;

   exp_t   sb_q[$];
   exp_t   mon_e;
   int     checks = 0;
   int     errors = 0;
   int     fb_period = 8;
   longint cyc = 0;
   longint last_valid = 0;
   logic   mon_en = 1'b0;

   pll_lock_detector #(
      .WINDOW_CYC(WINDOW_CYC),
      .CNT_W     (CNT_W),
      .TOL_W     (TOL_W),
      .LOCK_N    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fb_in     (fb_in),
      .target    (target),
      .tol       (tol),
      .meas_count(meas_count),
      .meas_valid(meas_valid),
      .too_fast  (too_fast),
      .too_slow  (too_slow),
      .lock      (lock)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic ok, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Feedback clock: period in clk cycles, 0 holds it low.
   initial begin
      forever begin
         if (fb_period == 0) begin
            fb_in = 1'b0;
            @(negedge clk);
         end else begin
            fb_in = 1'b1;
            repeat (fb_period / 2) @(negedge clk);
            fb_in = 1'b0;
            repeat (fb_period - fb_period / 2) @(negedge clk);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && meas_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_meas_valid", 1'b0, 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check("count_min", int'(meas_count) >= mon_e.lo, meas_count, mon_e.lo);
            check("count_max", int'(meas_count) <= mon_e.hi, meas_count, mon_e.hi);
            check("too_fast", too_fast == mon_e.tf, too_fast, mon_e.tf);
            check("too_slow", too_slow == mon_e.ts, too_slow, mon_e.ts);
            check("lock", lock == mon_e.lk, lock, mon_e.lk);
            if (mon_e.chk_per)
               check("window_period", (cyc - last_valid) == PER, cyc - last_valid, PER);
         end
         last_valid = cyc;
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 2 * PER + 50) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check("meas_valid_timeout", 1'b0, n, PER);
         sb_q.delete();
      end
   endtask

   task automatic expect_win(input int lo, input int hi, input logic tf, input logic ts,
                             input logic lk, input logic chk_per);
      exp_t e;
      e.lo = lo; e.hi = hi; e.tf = tf; e.ts = ts; e.lk = lk; e.chk_per = chk_per;
      sb_q.push_back(e);
      wait_drain();
   endtask

   initial begin
      // 1: reset with fb toggling
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_meas_count", meas_count == '0, meas_count, 0);
      check("rst_meas_valid", meas_valid == 1'b0, meas_valid, 0);
      check("rst_too_fast", too_fast == 1'b0, too_fast, 0);
      check("rst_too_slow", too_slow == 1'b0, too_slow, 0);
      check("rst_lock", lock == 1'b0, lock, 0);

      // 2: period 8 -> 128 edges per window, lock on 4th window
      rst    = 1'b0;
      target = 16'd128;
      tol    = 8'd2;
      en     = 1'b1;
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(127, 129, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_win(127, 129, 1'b0, 1'b0, 1'b1, 1'b1);

      // 3: period 7 -> ~146 edges, too fast
      fb_period = 7;
      expect_win(144, 148, 1'b1, 1'b0, HYST, 1'b1);
      expect_win(146, 147, 1'b1, 1'b0, 1'b0, 1'b1);

      // 4: static fb -> 0 edges, too slow
      fb_period = 0;
      expect_win(0, 3, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_win(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);

      // 5: relock at period 8, then abort a window with a 1-cycle en drop
      en = 1'b0;
      fb_period = 8;
      repeat (20) @(negedge clk);
      en = 1'b1;
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(127, 129, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (500) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("lock_after_abort", lock == 1'b0, lock, 0);
      check("meas_count_hold", (meas_count >= 16'd127) && (meas_count <= 16'd129), meas_count, 128);
      en = 1'b1;
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(127, 129, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(127, 129, 1'b0, 1'b0, 1'b1, 1'b1);

      // 6: wide target/tol, period 2 -> 512 edges, no wrap, too slow
      target    = 16'hFFFF;
      tol       = 8'hFF;
      fb_period = 2;
      expect_win(500, 512, 1'b0, 1'b1, HYST, 1'b1);
      expect_win(512, 512, 1'b0, 1'b1, 1'b0, 1'b1);
      fb_period = 0;
      expect_win(0, 3, 1'b0, 1'b1, 1'b0, 1'b1);
      target = 16'd0;
      tol    = 8'd0;
      expect_win(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_win(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
